ece423_nios_cpu_div_cell: RTL and testbench



---
 rtl/ece423_nios_cpu_div_cell.sv | 131 +++++++++++++
 tb/tb_ece423_nios_cpu_div_cell.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ece423_nios_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU and remainder; shares the E_src1/E_src2 operand bus.
// Latency: start accepted at edge 0, M_div_done high for one cycle after edge DATA_W+1.
// Backpressure: no queueing; a start while busy is dropped, and a flush aborts without a done pulse.
module ece423_nios_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              E_div_rem,
  input  logic              M_div_flush,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  // Operation context captured at the accepting edge; sign flags already folded with signed mode.
  typedef struct packed {
    logic              want_rem;
    logic              quo_neg;
    logic              dvd_neg;
    logic              dvsr_zero;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W-1:0] raw_dvd;
  } op_t;

  state_t            state, state_nxt;
  op_t               op_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              src1_neg, src2_neg;
  logic [DATA_W-1:0] src1_mag, src2_mag;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] quo_fix, rem_fix, fix_result;

  always_comb begin
    accept   = ((state == IDLE) || (state == DONE)) && E_div_start && !M_div_flush;
    src1_neg = E_div_signed && E_src1[DATA_W-1];
    src2_neg = E_div_signed && E_src2[DATA_W-1];
    src1_mag = src1_neg ? -E_src1 : E_src1;
    src2_mag = src2_neg ? -E_src2 : E_src2;
  end

  // diff[DATA_W] is the borrow: set when the shifted remainder is below the divisor.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, op_q.dvsr};
  end

  always_comb begin
    quo_fix = op_q.quo_neg ? -quo_q : quo_q;
    rem_fix = op_q.dvd_neg ? -rem_q : rem_q;
    if (op_q.dvsr_zero)
      fix_result = op_q.want_rem ? op_q.raw_dvd : '1;
    else
      fix_result = op_q.want_rem ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? ITER : IDLE;
      ITER: begin
        if (M_div_flush)
          state_nxt = IDLE;
        else if (cnt_q == '0)
          state_nxt = FIX;
      end
      FIX:     state_nxt = M_div_flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      M_div_result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q.want_rem  <= E_div_rem;
            op_q.quo_neg   <= src1_neg ^ src2_neg;
            op_q.dvd_neg   <= src1_neg;
            op_q.dvsr_zero <= (E_src2 == '0);
            op_q.dvsr      <= src2_mag;
            op_q.raw_dvd   <= E_src1;
            rem_q          <= '0;
            quo_q          <= src1_mag;
            cnt_q          <= CNT_W'(DATA_W - 1);
          end
        end
        ITER: begin
          quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
          rem_q <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          if (!M_div_flush)
            M_div_result <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign M_div_busy = (state == ITER) || (state == FIX);
  assign M_div_done = (state == DONE);

endmodule

// File: tb/tb_ece423_nios_cpu_div_cell.sv
// Directed bench for ece423_nios_cpu_div_cell: hand-computed results, fixed latency, handshake, flush and reset.
module tb_ece423_nios_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src1, src2;
  logic        start, sgn, remsel, flush;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam int LAT = 33;  // posedges from the accepting edge to the done cycle

  always #5 clk = ~clk;

  ece423_nios_cpu_div_cell #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (src1),
    .E_src2       (src2),
    .E_div_start  (start),
    .E_div_signed (sgn),
    .E_div_rem    (remsel),
    .M_div_flush  (flush),
    .M_div_busy   (busy),
    .M_div_done   (done),
    .M_div_result (result)
  );

  // Driver: presents one start, then waits (bounded) for done. lat=-1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic rm,
                        output logic [31:0] res, output int lat);
    src1 = a; src2 = b; sgn = sg; remsel = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; sgn = 1'b0; remsel = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int l;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, r, l);
    tests++; if (l !== LAT) begin fails++; $display("FAIL udiv_latency: got %0d expected %0d", l, LAT); end
    tests++; if (r !== 32'd14) begin fails++; $display("FAIL udiv_quo: got %h expected %h", r, 32'd14); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    tests++; if (result !== 32'd14) begin fails++; $display("FAIL result_hold: got %h expected %h", result, 32'd14); end
    run_op(32'd100, 32'd7, 1'b0, 1'b1, r, l);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL udiv_rem: got %h expected %h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int l;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, r, l);
    tests++; if (r !== 32'hFFFFFFFD) begin fails++; $display("FAIL sdiv_m7_2_quo: got %h expected FFFFFFFD", r); end
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, r, l);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL sdiv_m7_2_rem: got %h expected FFFFFFFF", r); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, r, l);
    tests++; if (r !== 32'hFFFFFFFD) begin fails++; $display("FAIL sdiv_7_m2_quo: got %h expected FFFFFFFD", r); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, r, l);
    tests++; if (r !== 32'd1) begin fails++; $display("FAIL sdiv_7_m2_rem: got %h expected 1", r); end
    tests++; if (l !== LAT) begin fails++; $display("FAIL sdiv_latency: got %0d expected %0d", l, LAT); end
  endtask

  task automatic test_boundary();
    logic [31:0] r; int l;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, r, l);
    tests++; if (r !== 32'h80000000) begin fails++; $display("FAIL ovf_quo: got %h expected 80000000", r); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, r, l);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL ovf_rem: got %h expected 0", r); end
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, r, l);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL umax_div1: got %h expected FFFFFFFF", r); end
    run_op(32'd5, 32'd0, 1'b0, 1'b0, r, l);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL udiv0_quo: got %h expected FFFFFFFF", r); end
    run_op(32'd5, 32'd0, 1'b0, 1'b1, r, l);
    tests++; if (r !== 32'd5) begin fails++; $display("FAIL udiv0_rem: got %h expected 5", r); end
    run_op(32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, r, l);
    tests++; if (r !== 32'hFFFFFFFB) begin fails++; $display("FAIL sdiv0_rem: got %h expected FFFFFFFB", r); end
    run_op(32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, r, l);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL sdiv0_quo: got %h expected FFFFFFFF", r); end
    tests++; if (l !== LAT) begin fails++; $display("FAIL div0_latency: got %0d expected %0d", l, LAT); end
  endtask

  task automatic test_ignore_start();
    int n_done; logic [31:0] r;
    @(posedge clk); #1;
    src1 = 32'd20; src2 = 32'd3; sgn = 1'b0; remsel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    src1 = 32'd1000; src2 = 32'd1; remsel = 1'b1;
    n_done = 0; r = 'x;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    start = 1'b0;
    for (int i = 33; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done) begin n_done++; r = result; end
    end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL busy_start_pulses: got %0d expected 1", n_done); end
    tests++; if (r !== 32'd6) begin fails++; $display("FAIL busy_start_result: got %h expected 6", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int l;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, r, l);
    tests++; if (r !== 32'd14) begin fails++; $display("FAIL b2b_first: got %h expected 14", r); end
    // Launched from the done cycle.
    run_op(32'd81, 32'd9, 1'b0, 1'b0, r, l);
    tests++; if (l !== LAT) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", l, LAT); end
    tests++; if (r !== 32'd9) begin fails++; $display("FAIL b2b_second: got %h expected 9", r); end
  endtask

  task automatic test_flush();
    int n_done;
    src1 = 32'd1000; src2 = 32'd10; sgn = 1'b0; remsel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b expected 0", busy); end
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL flush_no_done: got %0d expected 0", n_done); end
    tests++; if (result !== 32'd9) begin fails++; $display("FAIL flush_result_held: got %h expected 9", result); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    src1 = 32'd77; src2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_mid_result: got %h expected 0", result); end
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d expected 0", n_done); end
  endtask

  task automatic test_start_flush_idle();
    int n_done; logic [31:0] r; int l;
    src1 = 32'd50; src2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_flush_busy: got %b expected 0", busy); end
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL start_flush_no_done: got %0d expected 0", n_done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL start_flush_result: got %h expected 0", result); end
    run_op(32'd9, 32'd3, 1'b0, 1'b0, r, l);
    tests++; if (r !== 32'd3) begin fails++; $display("FAIL after_flush_op: got %h expected 3", r); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_start_flush_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
